// File: rtl/ps2_key_event_ctrl.sv
// ----------------------------------------------------------------------------
// ps2_key_event_ctrl
//
// Host-side controller that drains scan-code bytes from the ps2_keyboard
// receiver FIFO. It folds PS/2 set-2 prefixes (E0 extended, F0 break) into
// single key events and presents them on a valid/ready interface. Alongside
// the event stream it tracks the currently held key, marks typematic repeats,
// counts distinct presses and keeps sticky error / overflow flags.
//
// Parameters
//   CNT_W        width of press_count
//   DROP_REPEAT  nonzero: repeat makes are consumed silently, no event issued
//
// Ports
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   kbd_data      byte from ps2_keyboard, valid while kbd_ready=1
//   kbd_ready     ps2_keyboard device_ready (byte available)
//   kbd_overflow  ps2_keyboard FIFO overflow indication
//   host_valid_n  0 = a byte is popped this cycle if kbd_ready=1
//   evt_valid     key event pending
//   evt_ready     consumer accepts the pending event
//   evt_code      scan code with prefixes stripped
//   evt_ext       code was E0-prefixed
//   evt_break     1 = release, 0 = make
//   evt_repeat    make of the key that is already held
//   press_count   count of non-repeat makes, wraps
//   held_valid    a key is currently held
//   held_code     scan code of the held key
//   held_ext      extended flag of the held key
//   err_sticky    protocol error seen since last clear
//   ovf_sticky    kbd_overflow seen since last clear
//   clr_sticky    synchronous clear of both sticky flags
// ----------------------------------------------------------------------------
module ps2_key_event_ctrl #(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned DROP_REPEAT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       kbd_data,
    input  logic             kbd_ready,
    input  logic             kbd_overflow,
    output logic             host_valid_n,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [7:0]       evt_code,
    output logic             evt_ext,
    output logic             evt_break,
    output logic             evt_repeat,
    output logic [CNT_W-1:0] press_count,
    output logic             held_valid,
    output logic [7:0]       held_code,
    output logic             held_ext,
    output logic             err_sticky,
    output logic             ovf_sticky,
    input  logic             clr_sticky
);

    // FSM encoding
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_EXT    = 3'd1;
    localparam logic [2:0] S_BRK    = 3'd2;
    localparam logic [2:0] S_EXTBRK = 3'd3;
    localparam logic [2:0] S_OUT    = 3'd4;

    // Special bytes of the set-2 protocol
    localparam logic [7:0] B_EXT   = 8'hE0;
    localparam logic [7:0] B_BRK   = 8'hF0;
    localparam logic [7:0] B_PAUSE = 8'hE1;
    localparam logic [7:0] B_ERR0  = 8'h00;
    localparam logic [7:0] B_ERR1  = 8'hFF;

    logic [2:0]       state_q, state_d;
    logic             host_valid_n_q, host_valid_n_d;

    logic [7:0]       evt_code_q, evt_code_d;
    logic             evt_ext_q, evt_ext_d;
    logic             evt_break_q, evt_break_d;
    logic             evt_repeat_q, evt_repeat_d;

    logic [CNT_W-1:0] press_count_q, press_count_d;
    logic             held_valid_q, held_valid_d;
    logic [7:0]       held_code_q, held_code_d;
    logic             held_ext_q, held_ext_d;

    logic             err_q, err_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic             bad_byte;
    logic             cur_ext;
    logic             cur_brk;
    logic             held_match;
    logic             is_repeat;
    logic             drop_repeat;
    logic             proto_err;
    logic             form_event;

    // A byte is popped only while the handshake is open and data is present.
    assign accept   = !host_valid_n_q && kbd_ready;

    // 00 / FF are keyboard error indications; E1 (pause) is not supported.
    assign bad_byte = (kbd_data == B_ERR0) || (kbd_data == B_ERR1) ||
                      (kbd_data == B_PAUSE);

    // Prefix context accumulated so far for the byte being accepted.
    assign cur_ext  = (state_q == S_EXT) || (state_q == S_EXTBRK);
    assign cur_brk  = (state_q == S_BRK) || (state_q == S_EXTBRK);

    assign held_match  = held_valid_q &&
                         ({held_ext_q, held_code_q} == {cur_ext, kbd_data});
    assign is_repeat   = !cur_brk && held_match;
    assign drop_repeat = (DROP_REPEAT != 0) && is_repeat;

    // Prefix / state decoding
    always_comb begin
        state_d    = state_q;
        proto_err  = 1'b0;
        form_event = 1'b0;

        case (state_q)
            S_IDLE, S_EXT, S_BRK, S_EXTBRK: begin
                if (accept) begin
                    if (bad_byte) begin
                        proto_err = 1'b1;
                        state_d   = S_IDLE;
                    end else if (kbd_data == B_EXT) begin
                        // A second E0 mid-sequence restarts the extended sequence.
                        proto_err = (state_q != S_IDLE);
                        state_d   = S_EXT;
                    end else if (kbd_data == B_BRK) begin
                        // Duplicate F0 keeps the break context unchanged.
                        state_d = cur_ext ? S_EXTBRK : S_BRK;
                    end else begin
                        form_event = 1'b1;
                        state_d    = drop_repeat ? S_IDLE : S_OUT;
                    end
                end
            end
            S_OUT: begin
                if (evt_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Event fields, held-key tracking and press counting
    always_comb begin
        evt_code_d    = evt_code_q;
        evt_ext_d     = evt_ext_q;
        evt_break_d   = evt_break_q;
        evt_repeat_d  = evt_repeat_q;
        press_count_d = press_count_q;
        held_valid_d  = held_valid_q;
        held_code_d   = held_code_q;
        held_ext_d    = held_ext_q;

        // A dropped repeat leaves every piece of state untouched.
        if (form_event && !drop_repeat) begin
            evt_code_d   = kbd_data;
            evt_ext_d    = cur_ext;
            evt_break_d  = cur_brk;
            evt_repeat_d = is_repeat;

            if (!cur_brk) begin
                held_valid_d = 1'b1;
                held_code_d  = kbd_data;
                held_ext_d   = cur_ext;
                if (!is_repeat) begin
                    press_count_d = press_count_q + CNT_W'(1);
                end
            end else if (held_match) begin
                // Release of some other key leaves the held key in place.
                held_valid_d = 1'b0;
            end
        end
    end

    // Sticky flags: a same-cycle set takes priority over the clear.
    always_comb begin
        err_d = proto_err || (err_q && !clr_sticky);
        ovf_d = kbd_overflow || (ovf_q && !clr_sticky);
    end

    // Handshake closes exactly while an event is held for the consumer.
    always_comb begin
        host_valid_n_d = (state_d == S_OUT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            host_valid_n_q <= 1'b1;
            evt_code_q     <= 8'h00;
            evt_ext_q      <= 1'b0;
            evt_break_q    <= 1'b0;
            evt_repeat_q   <= 1'b0;
            press_count_q  <= '0;
            held_valid_q   <= 1'b0;
            held_code_q    <= 8'h00;
            held_ext_q     <= 1'b0;
            err_q          <= 1'b0;
            ovf_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            host_valid_n_q <= host_valid_n_d;
            evt_code_q     <= evt_code_d;
            evt_ext_q      <= evt_ext_d;
            evt_break_q    <= evt_break_d;
            evt_repeat_q   <= evt_repeat_d;
            press_count_q  <= press_count_d;
            held_valid_q   <= held_valid_d;
            held_code_q    <= held_code_d;
            held_ext_q     <= held_ext_d;
            err_q          <= err_d;
            ovf_q          <= ovf_d;
        end
    end

    assign host_valid_n = host_valid_n_q;
    assign evt_valid    = (state_q == S_OUT);
    assign evt_code     = evt_code_q;
    assign evt_ext      = evt_ext_q;
    assign evt_break    = evt_break_q;
    assign evt_repeat   = evt_repeat_q;
    assign press_count  = press_count_q;
    assign held_valid   = held_valid_q;
    assign held_code    = held_code_q;
    assign held_ext     = held_ext_q;
    assign err_sticky   = err_q;
    assign ovf_sticky   = ovf_q;

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ps2_key_event_ctrl
//
// Directed bench for ps2_key_event_ctrl. The main instance uses the default
// parameters; a second instance with DROP_REPEAT=1 is fed separately to check
// that repeat makes are swallowed.
// ----------------------------------------------------------------------------
module tb_ps2_key_event_ctrl;

    logic       clk;
    logic       rst_n;
    logic [7:0] kbd_data;
    logic       kbd_ready;
    logic       kbd_overflow;
    logic       host_valid_n;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_break;
    logic       evt_repeat;
    logic [7:0] press_count;
    logic       held_valid;
    logic [7:0] held_code;
    logic       held_ext;
    logic       err_sticky;
    logic       ovf_sticky;
    logic       clr_sticky;

    // Second instance (DROP_REPEAT=1)
    logic [7:0] k2_data;
    logic       k2_ready;
    logic       d2_host_valid_n;
    logic       d2_evt_valid;
    logic       e2_ready;
    logic [7:0] d2_evt_code;
    logic       d2_evt_ext;
    logic       d2_evt_break;
    logic       d2_evt_repeat;
    logic [7:0] d2_press_count;
    logic       d2_held_valid;
    logic [7:0] d2_held_code;
    logic       d2_held_ext;
    logic       d2_err_sticky;
    logic       d2_ovf_sticky;

    int tests;
    int fails;
    int ev2_cnt;
    int ev2_rep_cnt;

    ps2_key_event_ctrl #(.CNT_W(8), .DROP_REPEAT(0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .kbd_data     (kbd_data),
        .kbd_ready    (kbd_ready),
        .kbd_overflow (kbd_overflow),
        .host_valid_n (host_valid_n),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_code     (evt_code),
        .evt_ext      (evt_ext),
        .evt_break    (evt_break),
        .evt_repeat   (evt_repeat),
        .press_count  (press_count),
        .held_valid   (held_valid),
        .held_code    (held_code),
        .held_ext     (held_ext),
        .err_sticky   (err_sticky),
        .ovf_sticky   (ovf_sticky),
        .clr_sticky   (clr_sticky)
    );

    ps2_key_event_ctrl #(.CNT_W(8), .DROP_REPEAT(1)) dut_drop (
        .clk          (clk),
        .rst_n        (rst_n),
        .kbd_data     (k2_data),
        .kbd_ready    (k2_ready),
        .kbd_overflow (kbd_overflow),
        .host_valid_n (d2_host_valid_n),
        .evt_valid    (d2_evt_valid),
        .evt_ready    (e2_ready),
        .evt_code     (d2_evt_code),
        .evt_ext      (d2_evt_ext),
        .evt_break    (d2_evt_break),
        .evt_repeat   (d2_evt_repeat),
        .press_count  (d2_press_count),
        .held_valid   (d2_held_valid),
        .held_code    (d2_held_code),
        .held_ext     (d2_held_ext),
        .err_sticky   (d2_err_sticky),
        .ovf_sticky   (d2_ovf_sticky),
        .clr_sticky   (clr_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event monitor for the always-ready DROP_REPEAT instance.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ev2_cnt     <= 0;
            ev2_rep_cnt <= 0;
        end else if (d2_evt_valid && e2_ready) begin
            ev2_cnt <= ev2_cnt + 1;
            if (d2_evt_repeat) ev2_rep_cnt <= ev2_rep_cnt + 1;
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        rst_n        = 1'b0;
        kbd_ready    = 1'b0;
        kbd_data     = 8'h00;
        evt_ready    = 1'b0;
        clr_sticky   = 1'b0;
        kbd_overflow = 1'b0;
        k2_ready     = 1'b0;
        k2_data      = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Present one byte to the main instance and return right after it is popped.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        kbd_data  = b;
        kbd_ready = 1'b1;
        while (host_valid_n !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (host_valid_n !== 1'b0) begin
            fails++;
            $display("FAIL send_byte %02h: host_valid_n=%b after 50 cycles, required 0",
                     b, host_valid_n);
        end
        @(posedge clk);
        #1;
        kbd_ready = 1'b0;
    endtask

    task automatic send2(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        k2_data  = b;
        k2_ready = 1'b1;
        while (d2_host_valid_n !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (d2_host_valid_n !== 1'b0) begin
            fails++;
            $display("FAIL send2 %02h: host_valid_n=%b after 50 cycles, required 0",
                     b, d2_host_valid_n);
        end
        @(posedge clk);
        #1;
        k2_ready = 1'b0;
    endtask

    // Wait for an event, sample its fields and complete the handshake.
    task automatic get_event(output logic [7:0] c, output logic e, output logic b,
                             output logic r);
        int n;
        n = 0;
        @(negedge clk);
        while (evt_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (evt_valid !== 1'b1) begin
            fails++;
            $display("FAIL get_event: evt_valid=%b after 20 cycles, required 1", evt_valid);
        end
        c = evt_code;
        e = evt_ext;
        b = evt_break;
        r = evt_repeat;
        evt_ready = 1'b1;
        @(posedge clk);
        #1;
        evt_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({host_valid_n, evt_valid, evt_code, evt_ext, evt_break, evt_repeat, press_count,
             held_valid, held_code, held_ext, err_sticky, ovf_sticky} !== {1'b1, 32'h0}) begin
            fails++;
            $display("FAIL reset_outputs: got hv_n=%b valid=%b code=%02h cnt=%02h held=%b, want 1 0 00 00 0",
                     host_valid_n, evt_valid, evt_code, press_count, held_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if ({host_valid_n, evt_valid} !== 2'b00) begin
            fails++;
            $display("FAIL reset_release: hv_n,valid=%b%b, want 00", host_valid_n, evt_valid);
        end
    endtask

    task automatic test_single_make();
        logic [7:0] c;
        logic e, b, r;
        apply_reset();
        @(negedge clk);
        kbd_data  = 8'h1C;
        kbd_ready = 1'b1;
        tests++;
        if ({host_valid_n, evt_valid} !== 2'b00) begin
            fails++;
            $display("FAIL pre_accept: hv_n,valid=%b%b, want 00", host_valid_n, evt_valid);
        end
        @(posedge clk);
        #1;
        kbd_ready = 1'b0;
        tests++;
        if ({host_valid_n, evt_valid} !== 2'b11) begin
            fails++;
            $display("FAIL latency: hv_n,valid=%b%b one cycle after accept, want 11",
                     host_valid_n, evt_valid);
        end
        get_event(c, e, b, r);
        tests++;
        if ({c, e, b, r} !== {8'h1C, 3'b000}) begin
            fails++;
            $display("FAIL single_evt: code=%02h ext=%b brk=%b rep=%b, want 1C 0 0 0", c, e, b, r);
        end
        tests++;
        if ({press_count, held_valid, held_code, held_ext} !== {8'd1, 1'b1, 8'h1C, 1'b0}) begin
            fails++;
            $display("FAIL single_held: cnt=%0d held=%b code=%02h ext=%b, want 1 1 1C 0",
                     press_count, held_valid, held_code, held_ext);
        end
        @(negedge clk);
        tests++;
        if ({host_valid_n, evt_valid} !== 2'b00) begin
            fails++;
            $display("FAIL after_handshake: hv_n,valid=%b%b, want 00", host_valid_n, evt_valid);
        end
    endtask

    task automatic test_repeat();
        logic [7:0] c;
        logic e, b, r;
        apply_reset();
        send_byte(8'h1C);
        get_event(c, e, b, r);
        tests++;
        if ({c, e, b, r} !== {8'h1C, 3'b000}) begin
            fails++;
            $display("FAIL rep_first: code=%02h ext=%b brk=%b rep=%b, want 1C 0 0 0", c, e, b, r);
        end
        for (int i = 0; i < 2; i++) begin
            send_byte(8'h1C);
            get_event(c, e, b, r);
            tests++;
            if ({c, e, b, r} !== {8'h1C, 3'b001}) begin
                fails++;
                $display("FAIL rep_again%0d: code=%02h ext=%b brk=%b rep=%b, want 1C 0 0 1",
                         i, c, e, b, r);
            end
        end
        send_byte(8'hF0);
        send_byte(8'h1C);
        get_event(c, e, b, r);
        tests++;
        if ({c, e, b, r} !== {8'h1C, 3'b010}) begin
            fails++;
            $display("FAIL rep_break: code=%02h ext=%b brk=%b rep=%b, want 1C 0 1 0", c, e, b, r);
        end
        tests++;
        if ({press_count, held_valid} !== {8'd1, 1'b0}) begin
            fails++;
            $display("FAIL rep_counts: cnt=%0d held=%b, want 1 0", press_count, held_valid);
        end

        send2(8'h1C);
        send2(8'h1C);
        send2(8'h1C);
        send2(8'hF0);
        send2(8'h1C);
        repeat (4) @(negedge clk);
        tests++;
        if (ev2_cnt != 2 || ev2_rep_cnt != 0) begin
            fails++;
            $display("FAIL drop_repeat_events: events=%0d repeats=%0d, want 2 0",
                     ev2_cnt, ev2_rep_cnt);
        end
        tests++;
        if ({d2_press_count, d2_held_valid} !== {8'd1, 1'b0}) begin
            fails++;
            $display("FAIL drop_repeat_state: cnt=%0d held=%b, want 1 0",
                     d2_press_count, d2_held_valid);
        end
    endtask

    task automatic test_ext_stall();
        logic [7:0] c;
        logic e, b, r;
        apply_reset();
        send_byte(8'hE0);
        send_byte(8'h75);
        @(negedge clk);
        kbd_data  = 8'hE0;
        kbd_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tests++;
            if ({evt_valid, host_valid_n, evt_code, evt_ext, evt_break, evt_repeat} !==
                {2'b11, 8'h75, 3'b100}) begin
                fails++;
                $display("FAIL stall%0d: valid=%b hv_n=%b code=%02h ext=%b brk=%b rep=%b, want 1 1 75 1 0 0",
                         i, evt_valid, host_valid_n, evt_code, evt_ext, evt_break, evt_repeat);
            end
            @(negedge clk);
        end
        get_event(c, e, b, r);
        kbd_ready = 1'b0;
        tests++;
        if ({c, e, b, r} !== {8'h75, 3'b100}) begin
            fails++;
            $display("FAIL ext_make: code=%02h ext=%b brk=%b rep=%b, want 75 1 0 0", c, e, b, r);
        end
        tests++;
        if ({held_valid, held_code, held_ext} !== {1'b1, 8'h75, 1'b1}) begin
            fails++;
            $display("FAIL ext_held: held=%b code=%02h ext=%b, want 1 75 1",
                     held_valid, held_code, held_ext);
        end
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        get_event(c, e, b, r);
        tests++;
        if ({c, e, b, r} !== {8'h75, 3'b110}) begin
            fails++;
            $display("FAIL ext_break: code=%02h ext=%b brk=%b rep=%b, want 75 1 1 0", c, e, b, r);
        end
        tests++;
        if ({held_valid, err_sticky, press_count} !== {2'b00, 8'd1}) begin
            fails++;
            $display("FAIL ext_final: held=%b err=%b cnt=%0d, want 0 0 1",
                     held_valid, err_sticky, press_count);
        end
    endtask

    task automatic test_errors();
        logic [7:0] c;
        logic e, b, r;
        apply_reset();
        send_byte(8'hF0);
        send_byte(8'hE0);
        tests++;
        if (err_sticky !== 1'b1) begin
            fails++;
            $display("FAIL err_e0_in_brk: err_sticky=%b, want 1", err_sticky);
        end
        send_byte(8'h74);
        get_event(c, e, b, r);
        tests++;
        if ({c, e, b, r} !== {8'h74, 3'b100}) begin
            fails++;
            $display("FAIL err_restart_evt: code=%02h ext=%b brk=%b rep=%b, want 74 1 0 0",
                     c, e, b, r);
        end
        send_byte(8'hFF);
        repeat (3) @(negedge clk);
        tests++;
        if ({evt_valid, host_valid_n, press_count} !== {2'b00, 8'd1}) begin
            fails++;
            $display("FAIL ff_dropped: valid=%b hv_n=%b cnt=%0d, want 0 0 1",
                     evt_valid, host_valid_n, press_count);
        end
        clr_sticky = 1'b1;
        @(posedge clk);
        #1;
        clr_sticky = 1'b0;
        tests++;
        if ({err_sticky, ovf_sticky} !== 2'b00) begin
            fails++;
            $display("FAIL clr_sticky: err=%b ovf=%b, want 0 0", err_sticky, ovf_sticky);
        end
        // Overflow arriving in the same cycle as the clear must survive it.
        @(negedge clk);
        clr_sticky   = 1'b1;
        kbd_overflow = 1'b1;
        @(posedge clk);
        #1;
        clr_sticky   = 1'b0;
        kbd_overflow = 1'b0;
        tests++;
        if (ovf_sticky !== 1'b1) begin
            fails++;
            $display("FAIL set_beats_clr: ovf_sticky=%b, want 1", ovf_sticky);
        end
        // E1 inside an extended sequence aborts it back to idle.
        send_byte(8'hE0);
        send_byte(8'hE1);
        tests++;
        if (err_sticky !== 1'b1) begin
            fails++;
            $display("FAIL err_e1: err_sticky=%b, want 1", err_sticky);
        end
        send_byte(8'h1C);
        get_event(c, e, b, r);
        tests++;
        if ({c, e, b, r} !== {8'h1C, 3'b000}) begin
            fails++;
            $display("FAIL after_e1: code=%02h ext=%b brk=%b rep=%b, want 1C 0 0 0", c, e, b, r);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] c;
        logic [7:0] code;
        logic e, b, r;
        apply_reset();
        for (int i = 0; i < 256; i++) begin
            code = 8'h01 + 8'(i % 96);
            send_byte(code);
            get_event(c, e, b, r);
            send_byte(8'hF0);
            send_byte(code);
            get_event(c, e, b, r);
            if (i == 254) begin
                tests++;
                if (press_count !== 8'hFF) begin
                    fails++;
                    $display("FAIL count_255: press_count=%0d, want 255", press_count);
                end
            end
        end
        tests++;
        if ({press_count, held_valid} !== {8'h00, 1'b0}) begin
            fails++;
            $display("FAIL count_wrap: press_count=%0d held=%b, want 0 0", press_count, held_valid);
        end
        tests++;
        if (ovf_sticky !== 1'b0) begin
            fails++;
            $display("FAIL ovf_idle: ovf_sticky=%b, want 0", ovf_sticky);
        end
        @(negedge clk);
        kbd_overflow = 1'b1;
        @(negedge clk);
        kbd_overflow = 1'b0;
        @(negedge clk);
        tests++;
        if (ovf_sticky !== 1'b1) begin
            fails++;
            $display("FAIL ovf_set: ovf_sticky=%b, want 1", ovf_sticky);
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] c;
        logic e, b, r;
        apply_reset();
        send_byte(8'hE0);
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({host_valid_n, evt_valid, evt_code, evt_ext, evt_break, evt_repeat, press_count,
             held_valid, held_code, held_ext, err_sticky, ovf_sticky} !== {1'b1, 32'h0}) begin
            fails++;
            $display("FAIL rst_in_ext: hv_n=%b valid=%b, want 1 0", host_valid_n, evt_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_byte(8'h1C);
        get_event(c, e, b, r);
        tests++;
        if ({c, e, b, r} !== {8'h1C, 3'b000}) begin
            fails++;
            $display("FAIL post_rst_ext: code=%02h ext=%b brk=%b rep=%b, want 1C 0 0 0", c, e, b, r);
        end
        send_byte(8'h1C);
        tests++;
        if ({evt_valid, evt_repeat} !== 2'b11) begin
            fails++;
            $display("FAIL pend_repeat: valid=%b rep=%b, want 1 1", evt_valid, evt_repeat);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({host_valid_n, evt_valid, evt_code, evt_ext, evt_break, evt_repeat, press_count,
             held_valid, held_code, held_ext, err_sticky, ovf_sticky} !== {1'b1, 32'h0}) begin
            fails++;
            $display("FAIL rst_in_out: hv_n=%b valid=%b rep=%b cnt=%0d held=%b, want 1 0 0 0 0",
                     host_valid_n, evt_valid, evt_repeat, press_count, held_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_byte(8'h1C);
        get_event(c, e, b, r);
        tests++;
        if ({c, e, b, r} !== {8'h1C, 3'b000}) begin
            fails++;
            $display("FAIL post_rst_out: code=%02h ext=%b brk=%b rep=%b, want 1C 0 0 0", c, e, b, r);
        end
    endtask

    initial begin
        tests        = 0;
        fails        = 0;
        rst_n        = 1'b1;
        kbd_data     = 8'h00;
        kbd_ready    = 1'b0;
        kbd_overflow = 1'b0;
        evt_ready    = 1'b0;
        clr_sticky   = 1'b0;
        k2_data      = 8'h00;
        k2_ready     = 1'b0;
        e2_ready     = 1'b1;

        test_reset();
        test_single_make();
        test_repeat();
        test_ext_stall();
        test_errors();
        test_wrap();
        test_async_reset();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
